// File: rtl/score_award_sequencer_pkg.sv
// score_award_sequencer_pkg
//   Shared definitions for game-event feeders that drain an accumulated point
//   total into a score counter as single-cycle increment pulses.
//   Contents:
//     seq_state_e   - drain sequencer state encoding
//     max_award()   - largest single award for a given award width
//     accept_limit()- highest pending value at which a maximum award still fits
//     MaxAward, AcceptLimit - values of the above for the default widths
package score_award_sequencer_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StPulse = 2'd1,
      StWait  = 2'd2,
      StGap   = 2'd3
   } seq_state_e;

   localparam int unsigned DefaultPointsWidth  = 4;
   localparam int unsigned DefaultPendingWidth = 8;

   function automatic int unsigned max_award(input int unsigned points_width);
      return (32'd1 << points_width) - 32'd1;
   endfunction

   // Accepting at or below this level can never overflow the accumulator.
   function automatic int unsigned accept_limit(input int unsigned pending_width,
                                                input int unsigned points_width);
      return ((32'd1 << pending_width) - 32'd1) - max_award(points_width);
   endfunction

   localparam int unsigned MaxAward    = max_award(DefaultPointsWidth);
   localparam int unsigned AcceptLimit = accept_limit(DefaultPendingWidth, DefaultPointsWidth);

endpackage

// File: rtl/score_award_sequencer.sv
// score_award_sequencer
//   Accumulates multi-point awards into a pending total and drains it as one
//   registered enable pulse per point into a score counter, only while the
//   counter reports ready, with an optional idle gap after each pulse.
//   Ports:
//     clock          - system clock, rising edge
//     reset          - asynchronous active-high reset, clears all state
//     award_valid    - award present this cycle
//     award_points   - points in the award (0 is legal)
//     award_ready    - award accepted on an edge where valid && ready
//     counter_ready  - score counter can take an increment
//     counter_enable - registered single-cycle increment pulse
//     pending        - points accepted but not yet pulsed
//     busy           - pending != 0 or sequencer not idle
module score_award_sequencer
   import score_award_sequencer_pkg::*;
#(
   parameter int unsigned POINTS_WIDTH  = DefaultPointsWidth,
   parameter int unsigned PENDING_WIDTH = DefaultPendingWidth,
   parameter int unsigned GAP_CYCLES    = 0,
   parameter int unsigned GAP_WIDTH     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     award_valid,
   input  logic [POINTS_WIDTH-1:0]  award_points,
   output logic                     award_ready,
   input  logic                     counter_ready,
   output logic                     counter_enable,
   output logic [PENDING_WIDTH-1:0] pending,
   output logic                     busy
);

   localparam logic [PENDING_WIDTH-1:0] ACCEPT_LIMIT =
      PENDING_WIDTH'(accept_limit(PENDING_WIDTH, POINTS_WIDTH));
   localparam logic [GAP_WIDTH-1:0] GAP_LOAD =
      (GAP_CYCLES > 0) ? GAP_WIDTH'(GAP_CYCLES - 1) : '0;
   localparam bit HAS_GAP = (GAP_CYCLES > 0);

   seq_state_e               state_q;
   logic [PENDING_WIDTH-1:0] pending_q;
   logic [GAP_WIDTH-1:0]     gap_q;
   logic                     enable_q;

   logic pending_nz;
   logic accept;
   logic launch;

   assign pending_nz = |pending_q;

   // Back-pressure instead of wrapping: only accept while a full award fits.
   assign award_ready = (pending_q <= ACCEPT_LIMIT);
   assign accept      = award_valid & award_ready;

   // launch marks the edge on which the sequencer enters PULSE; it both
   // schedules the enable pulse and consumes one pending point.
   always_comb begin
      launch = 1'b0;
      case (state_q)
         StIdle:  launch = pending_nz & counter_ready;
         StWait:  launch = counter_ready & pending_nz & !HAS_GAP;
         StGap:   launch = (gap_q == '0) & pending_nz & counter_ready;
         default: launch = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         pending_q <= '0;
         gap_q     <= '0;
         enable_q  <= 1'b0;
      end else begin
         // Accept and launch may coincide; both apply on the same edge.
         pending_q <= pending_q
                      + (accept ? PENDING_WIDTH'(award_points) : '0)
                      - (launch ? PENDING_WIDTH'(1) : '0);
         enable_q  <= launch;

         case (state_q)
            StIdle: begin
               if (launch) state_q <= StPulse;
            end
            StPulse: begin
               state_q <= StWait;
            end
            StWait: begin
               // The counter may drop ready for a while after seeing enable.
               if (counter_ready) begin
                  if (HAS_GAP) begin
                     state_q <= StGap;
                     gap_q   <= GAP_LOAD;
                  end else if (launch) begin
                     state_q <= StPulse;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            StGap: begin
               if (gap_q == '0) begin
                  state_q <= launch ? StPulse : StIdle;
               end else begin
                  gap_q <= gap_q - GAP_WIDTH'(1);
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign counter_enable = enable_q;
   assign pending        = pending_q;
   assign busy           = pending_nz | (state_q != StIdle);

endmodule

// File: tb/tb_score_award_sequencer.sv
// tb_score_award_sequencer
//   Directed bench for score_award_sequencer. dut0 runs with no inter-pulse
//   gap, dut2 with a two-cycle gap. Outputs are sampled 1 time unit after the
//   rising edge; inputs are changed at the same point.
module tb_score_award_sequencer;

   logic       clock;
   logic       reset;

   logic       valid0, ready0, cready0, en0, busy0;
   logic [3:0] pts0;
   logic [7:0] pend0;

   logic       valid2, ready2, cready2, en2, busy2;
   logic [3:0] pts2;
   logic [7:0] pend2;

   int checks = 0;
   int errors = 0;
   int pulses;

   score_award_sequencer #(
      .POINTS_WIDTH (4),
      .PENDING_WIDTH(8),
      .GAP_CYCLES   (0)
   ) dut0 (
      .clock         (clock),
      .reset         (reset),
      .award_valid   (valid0),
      .award_points  (pts0),
      .award_ready   (ready0),
      .counter_ready (cready0),
      .counter_enable(en0),
      .pending       (pend0),
      .busy          (busy0)
   );

   score_award_sequencer #(
      .POINTS_WIDTH (4),
      .PENDING_WIDTH(8),
      .GAP_CYCLES   (2)
   ) dut2 (
      .clock         (clock),
      .reset         (reset),
      .award_valid   (valid2),
      .award_points  (pts2),
      .award_ready   (ready2),
      .counter_ready (cready2),
      .counter_enable(en2),
      .pending       (pend2),
      .busy          (busy2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Drain dut0 with counter_ready high, counting pulses, bounded by max_cycles.
   task automatic drain0(input int max_cycles, output int n);
      n = 0;
      cready0 = 1'b1;
      for (int i = 0; i < max_cycles; i++) begin
         tick();
         if (en0) n++;
         if (!busy0) break;
      end
   endtask

   initial begin
      reset   = 1'b1;
      valid0  = 1'b1;
      pts0    = 4'd5;
      cready0 = 1'b1;
      valid2  = 1'b1;
      pts2    = 4'd5;
      cready2 = 1'b1;

      // Reset held with an award offered: everything stays at reset values.
      tick();
      chk("rst_enable", en0, 0);
      chk("rst_pending", pend0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_award_ready", ready0, 1);
      chk("rst_pending_gap", pend2, 0);

      valid0 = 1'b0;
      valid2 = 1'b0;
      reset  = 1'b0;
      tick();
      tick();
      chk("post_rst_ready", ready0, 1);
      chk("post_rst_enable", en0, 0);
      chk("post_rst_pending", pend0, 0);

      // Award 3, no gap, ready held high.
      valid0 = 1'b1;
      pts0   = 4'd3;
      tick();                                   // edge 1
      valid0 = 1'b0;
      chk("a3_e1_pending", pend0, 3);
      chk("a3_e1_enable", en0, 0);
      chk("a3_e1_busy", busy0, 1);
      tick();                                   // edge 2
      chk("a3_e2_enable", en0, 1);
      chk("a3_e2_pending", pend0, 2);
      tick();                                   // edge 3
      chk("a3_e3_enable", en0, 0);
      tick();                                   // edge 4
      chk("a3_e4_enable", en0, 1);
      chk("a3_e4_pending", pend0, 1);
      tick();                                   // edge 5
      chk("a3_e5_enable", en0, 0);
      tick();                                   // edge 6
      chk("a3_e6_enable", en0, 1);
      chk("a3_e6_pending", pend0, 0);
      tick();                                   // edge 7: WAIT
      chk("a3_e7_enable", en0, 0);
      tick();                                   // edge 8: back to IDLE
      chk("a3_e8_busy", busy0, 0);
      chk("a3_e8_enable", en0, 0);

      // Counter not ready: award 5 is held, no pulse.
      cready0 = 1'b0;
      valid0  = 1'b1;
      pts0    = 4'd5;
      tick();
      valid0 = 1'b0;
      chk("nr_pending", pend0, 5);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("nr_enable", en0, 0);
         chk("nr_pending_hold", pend0, 5);
      end
      // Ready raised: 5 pulses, one every 2 cycles.
      cready0 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("nr_drain_enable", en0, ((i % 2) == 0) ? 1 : 0);
         chk("nr_drain_pending", pend0, 4 - i / 2);
      end
      tick();
      chk("nr_drain_idle", busy0, 0);

      // Simultaneous accept and pulse: 4 + 2 - 1 = 5.
      cready0 = 1'b0;
      valid0  = 1'b1;
      pts0    = 4'd4;
      tick();
      chk("sim_setup_pending", pend0, 4);
      cready0 = 1'b1;
      pts0    = 4'd2;
      tick();
      chk("sim_pending", pend0, 5);
      chk("sim_enable", en0, 1);
      valid0  = 1'b0;
      cready0 = 1'b0;                           // counter busy after the pulse
      tick();
      chk("wait_enable_a", en0, 0);
      tick();
      chk("wait_enable_b", en0, 0);
      chk("wait_pending", pend0, 5);
      // Zero-point award: accepted, no effect.
      valid0 = 1'b1;
      pts0   = 4'd0;
      chk("zero_ready", ready0, 1);
      tick();
      valid0 = 1'b0;
      chk("zero_pending", pend0, 5);
      chk("zero_enable", en0, 0);
      drain0(40, pulses);
      chk("zero_drain_pulses", pulses, 5);
      chk("zero_drain_done", busy0, 0);

      // Headroom: fill to 240 (still ready), then 241 (not ready).
      cready0 = 1'b0;
      valid0  = 1'b1;
      pts0    = 4'd15;
      for (int i = 0; i < 16; i++) tick();
      chk("fill_240_pending", pend0, 240);
      chk("fill_240_ready", ready0, 1);
      pts0 = 4'd1;
      tick();
      chk("fill_241_pending", pend0, 241);
      chk("fill_241_ready", ready0, 0);
      pts0 = 4'd15;                             // held, must not be accepted
      tick();
      chk("bp_hold_pending", pend0, 241);
      cready0 = 1'b1;
      tick();                                   // pulse only, award still blocked
      chk("bp_pulse_pending", pend0, 240);
      chk("bp_pulse_enable", en0, 1);
      chk("bp_ready_again", ready0, 1);
      cready0 = 1'b0;
      tick();                                   // held award accepted now
      valid0 = 1'b0;
      chk("bp_accept_pending", pend0, 255);
      chk("bp_full_ready", ready0, 0);
      drain0(600, pulses);
      chk("bp_drain_pulses", pulses, 255);
      chk("bp_drain_pending", pend0, 0);
      chk("bp_drain_done", busy0, 0);

      // Reset while a pulse is on the wire drops enable at once.
      valid0 = 1'b1;
      pts0   = 4'd2;
      tick();
      valid0 = 1'b0;
      tick();
      chk("rmp_enable_before", en0, 1);
      reset = 1'b1;
      #1;
      chk("rmp_enable", en0, 0);
      chk("rmp_pending", pend0, 0);
      chk("rmp_busy", busy0, 0);
      tick();
      reset = 1'b0;

      // Gap of 2: pulses 4 cycles apart; reset in the middle of a gap.
      valid2 = 1'b1;
      pts2   = 4'd3;
      tick();
      valid2 = 1'b0;
      chk("gap_pending", pend2, 3);
      tick();
      chk("gap_p0_enable", en2, 1);
      chk("gap_p0_pending", pend2, 2);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk("gap_between", en2, 0);
      end
      tick();
      chk("gap_p1_enable", en2, 1);
      chk("gap_p1_pending", pend2, 1);
      tick();                                   // WAIT
      tick();                                   // GAP
      chk("gap_mid_enable", en2, 0);
      reset = 1'b1;
      #1;
      chk("gap_rst_enable", en2, 0);
      chk("gap_rst_pending", pend2, 0);
      chk("gap_rst_busy", busy2, 0);
      #2;
      reset  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (en2) pulses++;
      end
      chk("gap_rst_no_pulses", pulses, 0);
      chk("gap_rst_pending_after", pend2, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
